// File: rtl/shared_reg_arbiter_if.sv
// Requester/register-bank bundle for shared_reg_arbiter.
// master drives requests and data; slave is the arbiter.
interface shared_reg_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             Req0;
    logic             Req1;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic             Gnt0;
    logic             Gnt1;
    logic             Ack0;
    logic             Ack1;
    logic [WIDTH-1:0] Q;
    logic             Busy;

    modport master (
        output Req0, Req1, D0, D1,
        input  Gnt0, Gnt1, Ack0, Ack1, Q, Busy
    );

    modport slave (
        input  Req0, Req1, D0, D1,
        output Gnt0, Gnt1, Ack0, Ack1, Q, Busy
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Two-requester arbiter/sequencer for a shared register: IDLE->LOAD->HOLD.
// SHREG_ROUND_ROBIN_EN selects alternating tie-break; default is fixed priority.
module shared_reg_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 3
) (
    input logic                 Clk,
    input logic                 Resetn,
    shared_reg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(HOLD - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             win_q, win_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic             pick;
    logic             req_w;
    logic [WIDTH-1:0] d_w;

`ifdef SHREG_ROUND_ROBIN_EN
    assign pick = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
`else
    assign pick = ~bus.Req0;
`endif

    assign req_w = win_q ? bus.Req1 : bus.Req0;
    assign d_w   = win_q ? bus.D1 : bus.D0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        q_d     = q_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    win_d   = pick;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (req_w) begin
                    q_d     = d_w;
                    ack0_d  = ~win_q;
                    ack1_d  = win_q;
                    last_d  = win_q;
                    cnt_d   = CNT_INIT;
                    state_d = S_HOLD;
                end else begin
                    // abort: owner withdrew, pointer untouched
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            q_q     <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
            q_q     <= q_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.Gnt0 = gnt0_q;
    assign bus.Gnt1 = gnt1_q;
    assign bus.Ack0 = ack0_q;
    assign bus.Ack1 = ack1_q;
    assign bus.Busy = busy_q;
endmodule
